axi_rd_arbiter: RTL and testbench
=================================

# axi_rd_arbiter

Two-requester read arbiter between the instruction-cache and data-cache class-AXI read ports and the single AXI read channel (AR/R) of the CPU top. It grants one requester at a time, translates the class-AXI read type into AR burst fields, carries exactly one outstanding transaction, and steers returned beats back to the owner. The write path is out of scope and is handled elsewhere.

## Interface
- Parameters:
  - `INST_ID`, default 4'd0: `arid` used for instruction reads.
  - `DATA_ID`, default 4'd1: `arid` used for data reads.
- Ports:
  - `aclk` in 1: clock. One clock; all logic on the rising edge.
  - `areset` in 1: reset. Synchronous, active-high.
  - `inst_rd_req` in 1; `inst_rd_type` in 3; `inst_rd_addr` in 32: instruction read request.
  - `inst_rd_rdy` out 1: instruction request accepted this cycle.
  - `inst_ret_valid` out 1; `inst_ret_last` out 1; `inst_ret_data` out 32: instruction return beat.
  - `data_rd_req` in 1; `data_rd_type` in 3; `data_rd_addr` in 32: data read request.
  - `data_rd_rdy` out 1: data request accepted this cycle.
  - `data_ret_valid` out 1; `data_ret_last` out 1; `data_ret_data` out 32: data return beat.
  - `arid` out 4; `araddr` out 32; `arlen` out 8; `arsize` out 3; `arburst` out 2; `arvalid` out 1: AXI read address channel.
  - `arready` in 1: AXI read address ready.
  - `rid` in 4; `rdata` in 32; `rresp` in 2; `rlast` in 1; `rvalid` in 1: AXI read data channel.
  - `rready` out 1: AXI read data ready.
  - `rd_err` out 1: sticky protocol/response error flag.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE
  - `xx_rd_rdy` is high only for the granted requester, and only while that requester drives `xx_rd_req`.
  - On `req & rdy`, latch owner, address and type, then go to ADDR.
- ADDR
  - `arvalid`=1 with the latched fields.
  - On `arready`, go to DATA and clear the beat counter.
- DATA
  - `rready`=1.
  - Each `rvalid` beat drives the owner's `ret_valid`=1, `ret_data`=`rdata` and `ret_last`=`rlast`. The other requester's `ret_valid` stays 0.
  - On `rvalid & rlast`, return to IDLE.
- Type translation:
  - `3'b000` gives `arsize`=0, `arlen`=0.
  - `3'b001` gives `arsize`=1, `arlen`=0.
  - `3'b010` gives `arsize`=2, `arlen`=0.
  - `3'b100` (cache line) gives `arsize`=2, `arlen`=3.
  - Any other value is treated as `3'b010`.
  - `arburst`=2'b01 (INCR) always.
- `arid` = `INST_ID` or `DATA_ID` according to the owner.
- Beat counter is 2 bits and increments on each accepted beat. `rd_err` sets and stays set until reset on any of:
  - `rlast` arrives with counter != latched `arlen[1:0]`;
  - `rresp` != 0;
  - `rid` differs from the issued `arid`.
  - Data is still forwarded on an error.
- `rvalid` outside DATA is ignored (`rready`=0).
- Default grant (no `RD_ARB_RR_EN`): fixed priority, data over instruction.

## Timing
- Reset values:
  - State = IDLE.
  - `arvalid`, `rready`, every `rd_rdy`, every `ret_valid`, every `ret_last` and `rd_err` = 0.
  - `araddr`, `arlen`, `arsize` and `arid` registers = 0; `arburst` = 2'b01.
  - Round-robin pointer = instruction first.
- `rd_rdy` is combinational from state, grant and `req`.
- `arvalid` rises the cycle after acceptance and holds with stable fields until `arready`. There is a minimum 1 cycle from acceptance to AR handshake.
- Return path is combinational from R to the owner: zero added latency per beat.
- Back-to-back: the cycle after the last beat is IDLE, so a new accept is possible there. Minimum AR-to-AR spacing is 3 cycles for single beats with zero-latency slave.
- Both requests asserted in the same IDLE cycle: exactly one `rd_rdy` asserts. The loser remains pending and is not lost.
- Requester drops `req` before `rdy`: no transaction is issued.
- Reset mid-ADDR or mid-DATA: return to IDLE next edge with all outputs at reset values. The interrupted transaction is abandoned (system-wide reset only).

## Configuration
- Macro: `RD_ARB_RR_EN`.
- Defined: round-robin grant. A 1-bit pointer flips to the other requester after each accepted request. When both request, the pointed-to requester wins; a lone requester always wins.
- Undefined: fixed priority, data over instruction. The pointer logic is not built.

## Test plan
- Single data word read, addr 0x1C000010, type 3'b010: `arvalid` with `araddr`=0x1C000010, `arlen`=0, `arsize`=2, `arid`=1. One `data_ret_valid` beat with `ret_last`=1 and `rdata` 0xDEADBEEF passed through. `inst_ret_valid` stays 0.
- Instruction cache-line read, type 3'b100: `arlen`=3, `arid`=0. Four `inst_ret_valid` beats; `inst_ret_last` only on the 4th. `rd_err`=0.
- Simultaneous inst/data requests, held for 3 transactions:
  - Default build: data granted first; instruction granted after the data burst completes.
  - `RD_ARB_RR_EN` build: grants alternate inst, data, inst.
- `arready` held low for 5 cycles: `arvalid` and all AR fields are stable for all 5 cycles, and no second `rd_rdy` asserts.
- Line read with `rlast` on the 2nd beat, or with `rresp`=2'b10: `rd_err`=1 and it stays 1 until `areset`.
- `areset` asserted on the 2nd beat of a line read: the next cycle shows state IDLE, `rready`=0 and `rd_err`=0. A fresh request afterwards completes normally.

Source files
------------

// File: rtl/axi_rd_arbiter_if.sv
// Bus bundle for axi_rd_arbiter: both class-AXI read request/return ports,
// the single AXI read address/data channel and the sticky error flag.
// modport master is the arbiter side; modport slave is the surrounding system.
interface axi_rd_arbiter_if;
  // instruction-cache read port
  logic        inst_rd_req;
  logic [2:0]  inst_rd_type;
  logic [31:0] inst_rd_addr;
  logic        inst_rd_rdy;
  logic        inst_ret_valid;
  logic        inst_ret_last;
  logic [31:0] inst_ret_data;

  // data-cache read port
  logic        data_rd_req;
  logic [2:0]  data_rd_type;
  logic [31:0] data_rd_addr;
  logic        data_rd_rdy;
  logic        data_ret_valid;
  logic        data_ret_last;
  logic [31:0] data_ret_data;

  // AXI read address channel
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  // AXI read data channel
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic        rd_err;

  modport master (
    input  inst_rd_req, inst_rd_type, inst_rd_addr,
    output inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
    input  data_rd_req, data_rd_type, data_rd_addr,
    output data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output rd_err
  );

  modport slave (
    output inst_rd_req, inst_rd_type, inst_rd_addr,
    input  inst_rd_rdy, inst_ret_valid, inst_ret_last, inst_ret_data,
    output data_rd_req, data_rd_type, data_rd_addr,
    input  data_rd_rdy, data_ret_valid, data_ret_last, data_ret_data,
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  rd_err
  );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-requester AXI read arbiter (instruction cache / data cache) onto one
// AR/R channel with a single outstanding transaction.
// Optional macro RD_ARB_RR_EN: round-robin grant between the two requesters.
// Without it the grant is fixed priority, data over instruction.
//
// state | meaning
// IDLE  | no transaction; grant offered to a requester, accept latches it
// ADDR  | arvalid high with latched fields, waiting for arready
// DATA  | rready high, R beats steered to the owner until rlast
module axi_rd_arbiter #(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input logic             aclk,
  input logic             areset,
  axi_rd_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        owner_data;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic [3:0]  id_q;
  logic [1:0]  beat_cnt;
  logic        err_q;

  logic        grant_inst;
  logic        grant_data;
  logic        accept;
  logic        accept_data;
  logic        ar_done;
  logic        beat;
  logic        beat_err;

  logic [2:0]  sel_type;
  logic [31:0] sel_addr;
  logic [7:0]  len_xl;
  logic [2:0]  size_xl;

`ifdef RD_ARB_RR_EN
  // rr_ptr = 1 means the data requester wins a tie
  logic rr_ptr;

  // Tie goes to the pointed-to requester; a lone requester always wins
  always_comb begin
    grant_data = bus.data_rd_req & (~bus.inst_rd_req | rr_ptr);
    grant_inst = bus.inst_rd_req & (~bus.data_rd_req | ~rr_ptr);
  end

  // Pointer moves to the other requester after every accepted request
  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~accept_data;
    end
  end
`else
  // Fixed priority: data beats instruction
  always_comb begin
    grant_data = bus.data_rd_req;
    grant_inst = bus.inst_rd_req & ~bus.data_rd_req;
  end
`endif

  // Select the accepted request and translate its type into AR burst fields
  always_comb begin
    sel_type = accept_data ? bus.data_rd_type : bus.inst_rd_type;
    sel_addr = accept_data ? bus.data_rd_addr : bus.inst_rd_addr;
    len_xl   = 8'd0;
    size_xl  = 3'd2;
    case (sel_type)
      3'b000:  size_xl = 3'd0;
      3'b001:  size_xl = 3'd1;
      3'b010:  size_xl = 3'd2;
      3'b100: begin
        size_xl = 3'd2;
        len_xl  = 8'd3;
      end
      default: size_xl = 3'd2;
    endcase
  end

  // Next state plus all handshake and return-path outputs
  always_comb begin
    state_nxt          = state;
    bus.inst_rd_rdy    = 1'b0;
    bus.data_rd_rdy    = 1'b0;
    bus.arvalid        = 1'b0;
    bus.rready         = 1'b0;
    bus.inst_ret_valid = 1'b0;
    bus.inst_ret_last  = 1'b0;
    bus.data_ret_valid = 1'b0;
    bus.data_ret_last  = 1'b0;
    accept             = 1'b0;
    accept_data        = 1'b0;
    ar_done            = 1'b0;
    beat               = 1'b0;

    case (state)
      IDLE: begin
        bus.inst_rd_rdy = grant_inst;
        bus.data_rd_rdy = grant_data;
        accept          = grant_inst | grant_data;
        accept_data     = grant_data;
        if (accept) state_nxt = ADDR;
      end
      ADDR: begin
        bus.arvalid = 1'b1;
        ar_done     = bus.arready;
        if (bus.arready) state_nxt = DATA;
      end
      DATA: begin
        bus.rready = 1'b1;
        beat       = bus.rvalid;
        if (owner_data) begin
          bus.data_ret_valid = bus.rvalid;
          bus.data_ret_last  = bus.rvalid & bus.rlast;
        end else begin
          bus.inst_ret_valid = bus.rvalid;
          bus.inst_ret_last  = bus.rvalid & bus.rlast;
        end
        if (bus.rvalid && bus.rlast) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Returned data fans out to both ports; only the owner's valid qualifies it
  always_comb begin
    bus.inst_ret_data = bus.rdata;
    bus.data_ret_data = bus.rdata;
    bus.arid          = id_q;
    bus.araddr        = addr_q;
    bus.arlen         = len_q;
    bus.arsize        = size_q;
    bus.arburst       = 2'b01;
    bus.rd_err        = err_q;
  end

  // Beat with wrong-length burst end, error response or foreign id
  always_comb begin
    beat_err = beat & ((bus.rlast && (beat_cnt != len_q[1:0])) ||
                       (bus.rresp != 2'b00) ||
                       (bus.rid != id_q));
  end

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch owner and AR fields at acceptance; held stable through ADDR and DATA
  always_ff @(posedge aclk) begin
    if (areset) begin
      owner_data <= 1'b0;
      addr_q     <= 32'd0;
      len_q      <= 8'd0;
      size_q     <= 3'd0;
      id_q       <= 4'd0;
    end else if (accept) begin
      owner_data <= accept_data;
      addr_q     <= sel_addr;
      len_q      <= len_xl;
      size_q     <= size_xl;
      id_q       <= accept_data ? DATA_ID : INST_ID;
    end
  end

  // Beat counter: cleared on the AR handshake, counts accepted R beats
  always_ff @(posedge aclk) begin
    if (areset) begin
      beat_cnt <= 2'd0;
    end else if (ar_done) begin
      beat_cnt <= 2'd0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + 2'd1;
    end
  end

  // Sticky error flag, cleared only by reset
  always_ff @(posedge aclk) begin
    if (areset) begin
      err_q <= 1'b0;
    end else if (beat_err) begin
      err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Self-checking bench for axi_rd_arbiter: directed scenarios plus randomized
// transactions, checked against a transaction-level model of grant, AR
// translation, return steering and the sticky error flag.
module tb_axi_rd_arbiter;

  localparam logic [3:0] INST_ID = 4'd0;
  localparam logic [3:0] DATA_ID = 4'd1;

  logic aclk;
  logic areset;

  axi_rd_arbiter_if bus ();

  axi_rd_arbiter #(.INST_ID(INST_ID), .DATA_ID(DATA_ID)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  int          n_vec;
  int          n_err;
  bit          exp_err;
  bit          ptr_model;   // 1 = data wins a tie (round-robin build)
  logic [31:0] force_data;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.inst_rd_req  = 1'b0;
    bus.inst_rd_type = 3'b000;
    bus.inst_rd_addr = 32'd0;
    bus.data_rd_req  = 1'b0;
    bus.data_rd_type = 3'b000;
    bus.data_rd_addr = 32'd0;
    bus.arready      = 1'b0;
    bus.rid          = 4'd0;
    bus.rdata        = 32'd0;
    bus.rresp        = 2'b00;
    bus.rlast        = 1'b0;
    bus.rvalid       = 1'b0;
  endtask

  // Reset for two cycles and check every output against its reset value
  task automatic do_reset();
    idle_inputs();
    areset = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    areset    = 1'b0;
    exp_err   = 1'b0;
    ptr_model = 1'b0;
    #1;
    chk("rst_arvalid", bus.arvalid, 0);
    chk("rst_rready", bus.rready, 0);
    chk("rst_rd_err", bus.rd_err, 0);
    chk("rst_ret_valid", {bus.inst_ret_valid, bus.data_ret_valid}, 0);
    chk("rst_ret_last", {bus.inst_ret_last, bus.data_ret_last}, 0);
    chk("rst_rdy", {bus.inst_rd_rdy, bus.data_rd_rdy}, 0);
    chk("rst_araddr", bus.araddr, 0);
    chk("rst_arlen_size_id", {bus.arlen, bus.arsize, bus.arid}, 0);
    chk("rst_arburst", bus.arburst, 2'b01);
  endtask

  // One transaction. mode: 0 normal, 1 rlast on 2nd beat, 2 rresp=SLVERR on
  // 1st beat, 3 reset on the 2nd beat. Called at posedge+1 with DUT in IDLE.
  task automatic txn(input bit ri, input bit rd,
                     input logic [2:0] ti, input logic [31:0] ai,
                     input logic [2:0] td, input logic [31:0] ad,
                     input int ar_wait, input int mode, output bit won_data);
    bit          wd;
    bit          tie_data;
    bit          did_rst;
    logic [2:0]  t;
    logic [31:0] a;
    int          exp_len;
    int          exp_size;
    logic [3:0]  exp_id;
    int          nbeats;
    int          nb;
    int          cyc;

`ifdef RD_ARB_RR_EN
    tie_data = ptr_model;
`else
    tie_data = 1'b1;
`endif
    wd        = (ri && rd) ? tie_data : rd;
    ptr_model = !wd;
    t         = wd ? td : ti;
    a         = wd ? ad : ai;
    exp_len   = (t == 3'b100) ? 3 : 0;
    exp_size  = (t == 3'b000) ? 0 : (t == 3'b001) ? 1 : 2;
    exp_id    = wd ? DATA_ID : INST_ID;

    bus.inst_rd_req  = ri;
    bus.inst_rd_type = ti;
    bus.inst_rd_addr = ai;
    bus.data_rd_req  = rd;
    bus.data_rd_type = td;
    bus.data_rd_addr = ad;
    bus.rvalid       = 1'b0;
    bus.arready      = 1'b0;
    #1;
    chk("grant_data", bus.data_rd_rdy, wd);
    chk("grant_inst", bus.inst_rd_rdy, !wd);
    chk("idle_arvalid", bus.arvalid, 0);
    @(posedge aclk);
    #1;
    if (wd) bus.data_rd_req = 1'b0;
    else    bus.inst_rd_req = 1'b0;

    for (int k = 0; k <= ar_wait; k++) begin
      bus.arready = (k == ar_wait);
      bus.rvalid  = ($urandom_range(0, 1) == 1);
      bus.rlast   = 1'b1;
      bus.rdata   = $urandom;
      #1;
      chk("ar_valid", bus.arvalid, 1);
      chk("ar_addr", bus.araddr, a);
      chk("ar_len", bus.arlen, exp_len);
      chk("ar_size", bus.arsize, exp_size);
      chk("ar_id", bus.arid, exp_id);
      chk("ar_burst", bus.arburst, 2'b01);
      chk("ar_no_rdy", {bus.inst_rd_rdy, bus.data_rd_rdy}, 0);
      chk("ar_rready", bus.rready, 0);
      chk("ar_no_ret", {bus.inst_ret_valid, bus.data_ret_valid}, 0);
      @(posedge aclk);
      #1;
    end
    bus.arready = 1'b0;

    nbeats  = (mode == 1) ? 2 : exp_len + 1;
    nb      = 0;
    did_rst = 1'b0;
    for (cyc = 0; cyc < 64 && nb < nbeats && !did_rst; cyc++) begin
      bus.rvalid = ($urandom_range(0, 3) != 0);
      bus.rdata  = (force_data != 32'd0) ? force_data : $urandom;
      bus.rid    = exp_id;
      bus.rresp  = (mode == 2 && nb == 0) ? 2'b10 : 2'b00;
      bus.rlast  = (nb == nbeats - 1);
      if (mode == 3 && nb == 1 && bus.rvalid) areset = 1'b1;
      #1;
      chk("r_rready", bus.rready, 1);
      if (wd) begin
        chk("r_own_valid", bus.data_ret_valid, bus.rvalid);
        chk("r_own_last", bus.data_ret_last, bus.rvalid & bus.rlast);
        chk("r_other_valid", bus.inst_ret_valid, 0);
        if (bus.rvalid) chk("r_data", bus.data_ret_data, bus.rdata);
      end else begin
        chk("r_own_valid", bus.inst_ret_valid, bus.rvalid);
        chk("r_own_last", bus.inst_ret_last, bus.rvalid & bus.rlast);
        chk("r_other_valid", bus.data_ret_valid, 0);
        if (bus.rvalid) chk("r_data", bus.inst_ret_data, bus.rdata);
      end
      @(posedge aclk);
      #1;
      if (areset) begin
        did_rst   = 1'b1;
        areset    = 1'b0;
        exp_err   = 1'b0;
        ptr_model = 1'b0;
      end else if (bus.rvalid) begin
        nb++;
      end
    end
    chk("r_complete", (nb == nbeats) || did_rst, 1);
    if (!did_rst && (mode == 1 || mode == 2)) exp_err = 1'b1;

    idle_inputs();
    #1;
    chk("end_rready", bus.rready, 0);
    chk("end_arvalid", bus.arvalid, 0);
    chk("end_rd_err", bus.rd_err, exp_err);
    if (did_rst) chk("end_rst_araddr", bus.araddr, 0);
    won_data = wd;
  endtask

  initial begin
    bit w;
    bit ri;
    bit rd;
    int r;
    n_vec      = 0;
    n_err      = 0;
    exp_err    = 1'b0;
    ptr_model  = 1'b0;
    force_data = 32'd0;
    areset     = 1'b1;
    idle_inputs();

    do_reset();

    // single data word read with a known payload
    force_data = 32'hDEADBEEF;
    txn(1'b0, 1'b1, 3'b000, 32'd0, 3'b010, 32'h1C000010, 0, 0, w);
    force_data = 32'd0;

    // instruction cache-line read
    txn(1'b1, 1'b0, 3'b100, 32'h1C000100, 3'b000, 32'd0, 0, 0, w);

    // simultaneous requests; the loser stays pending for the next round
    txn(1'b1, 1'b1, 3'b100, 32'h00000200, 3'b010, 32'h00000300, 0, 0, w);
    txn(w, !w, 3'b100, 32'h00000200, 3'b010, 32'h00000300, 1, 0, w);
    txn(1'b1, 1'b1, 3'b001, 32'h00000400, 3'b000, 32'h00000500, 0, 0, w);

    // arready held off for 5 cycles
    txn(1'b0, 1'b1, 3'b000, 32'd0, 3'b100, 32'h80001000, 5, 0, w);

    // early rlast: error sets and survives the next clean transaction
    txn(1'b1, 1'b0, 3'b100, 32'h00002000, 3'b000, 32'd0, 0, 1, w);
    txn(1'b0, 1'b1, 3'b000, 32'd0, 3'b010, 32'h00002100, 0, 0, w);
    do_reset();

    // error response on a line read
    txn(1'b0, 1'b1, 3'b000, 32'd0, 3'b100, 32'h00003000, 1, 2, w);
    txn(1'b1, 1'b0, 3'b010, 32'h00003100, 3'b000, 32'd0, 0, 0, w);
    do_reset();

    // reset on the second beat, then a fresh request
    txn(1'b1, 1'b0, 3'b100, 32'h00004000, 3'b000, 32'd0, 0, 3, w);
    txn(1'b1, 1'b1, 3'b010, 32'h00004100, 3'b100, 32'h00004200, 0, 0, w);

    // request dropped before acceptance issues nothing
    bus.data_rd_req  = 1'b1;
    bus.data_rd_addr = 32'h00005000;
    #1;
    chk("drop_rdy", bus.data_rd_rdy, 1);
    bus.data_rd_req = 1'b0;
    @(posedge aclk);
    #1;
    chk("drop_arvalid0", bus.arvalid, 0);
    @(posedge aclk);
    #1;
    chk("drop_arvalid1", bus.arvalid, 0);

    // randomized traffic, all types including undefined encodings
    for (int n = 0; n < 24; n++) begin
      r  = $urandom_range(1, 3);
      ri = (r != 2);
      rd = (r != 1);
      txn(ri, rd, 3'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3), 0, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
